ras_circular: RTL

Parametrised circular return-address stack (RAS) for the frontend branch predictor. Depth and address width come from the core configuration (`RASDepth`, `VLEN`). It adds four things a fixed-depth shift-register RAS does not have:
- wrap-around overwrite on overflow;
- atomic push+pop (coroutine) handling;
- pointer checkpoint/restore for misprediction recovery;
- overflow/underflow event pulses for the performance counters.

---
 rtl/ras_circular.sv | 99 +++++++++
 1 files changed

// File: rtl/ras_circular.sv
// Circular return-address stack with wrap-around overwrite, atomic push+pop,
// pointer checkpoint/restore and registered overflow/underflow event pulses.
module ras_circular #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned PTR_W  = DEPTH > 1 ? $clog2(DEPTH) : 1,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              restore_i,
  input  logic [PTR_W-1:0]  restore_ptr_i,
  input  logic [CNT_W-1:0]  restore_cnt_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] data_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [PTR_W-1:0]  ckpt_ptr_o,
  output logic [CNT_W-1:0]  ckpt_cnt_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam logic [PTR_W-1:0] TopRst = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] Full   = CNT_W'(DEPTH);
  localparam logic [PTR_W:0]   DepthW = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  tp_q, tp_d, tp_inc, tp_dec, waddr;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, we;

  always_comb begin
    tp_inc = (tp_q == TopRst) ? '0 : tp_q + 1'b1;
    tp_dec = (tp_q == '0) ? TopRst : tp_q - 1'b1;
  end

  always_comb begin
    tp_d  = tp_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    we    = 1'b0;
    waddr = tp_inc;
    if (flush_i) begin
      tp_d  = TopRst;
      cnt_d = '0;
    end else if (restore_i) begin
      tp_d  = ({1'b0, restore_ptr_i} >= DepthW) ? '0 : restore_ptr_i;
      cnt_d = (restore_cnt_i > Full) ? Full : restore_cnt_i;
    end else if (push_i && pop_i && cnt_q != '0) begin
      // Coroutine switch: replace the top in place.
      we    = 1'b1;
      waddr = tp_q;
    end else if (push_i) begin
      tp_d = tp_inc;
      we   = 1'b1;
      if (cnt_q == Full) ovf_d = 1'b1;
      else               cnt_d = cnt_q + 1'b1;
    end else if (pop_i) begin
      if (cnt_q != '0) begin
        tp_d  = tp_dec;
        cnt_d = cnt_q - 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tp_q  <= TopRst;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (we) mem_q[waddr] <= data_i;
    end
  end

  always_comb begin
    valid_o     = (cnt_q != '0);
    data_o      = valid_o ? mem_q[tp_q] : '0;
    count_o     = cnt_q;
    ckpt_cnt_o  = cnt_q;
    ckpt_ptr_o  = tp_q;
    overflow_o  = ovf_q;
    underflow_o = unf_q;
  end

endmodule
